// File: rtl/codma_bus_pkg.sv
// Shared constants and the responder state type for the CoDMA bus responder.
// The optional read-stall LFSR (CODMA_RESP_STALL_INJECT_EN) draws its seed from here.
package codma_bus_pkg;

  localparam int          DATA_SIZE_DEF = 32;
  localparam int          ADDR_SIZE_DEF = 32;
  localparam int          SIZE_W        = 4;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_GRANT   = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_ERR     = 3'd5
  } resp_state_e;

endpackage

// File: rtl/codma_resp_ram.sv
// Single-port synchronous RAM, one-cycle read latency; only the read register is reset.
module codma_resp_ram #(
  parameter int DATA_SIZE = 32,
  parameter int MEM_WORDS = 1024,
  localparam int AW       = $clog2(MEM_WORDS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [AW-1:0]        i_addr,
  input  logic [DATA_SIZE-1:0] i_wdata,
  output logic [DATA_SIZE-1:0] o_rdata
);

  logic [DATA_SIZE-1:0] r_mem [MEM_WORDS];
  logic [DATA_SIZE-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // Output only moves on a read, so it holds the last beat between reads.
  always_ff @(posedge i_clk) begin
    if (i_reset)   r_q <= '0;
    else if (i_re) r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/codma_bus_responder.sv
// CoDMA bus_if responder: word-addressed memory answering read/write bursts.
// Define CODMA_RESP_STALL_INJECT_EN to inject pseudo-random read bubbles.
module codma_bus_responder
  import codma_bus_pkg::*;
#(
  parameter int DATA_SIZE     = DATA_SIZE_DEF,
  parameter int ADDR_SIZE     = ADDR_SIZE_DEF,
  parameter int MEM_WORDS     = 1024,
  parameter int GRANT_LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 read_request,
  input  logic                 write_request,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [SIZE_W-1:0]    size,
  output logic                 grant,
  output logic                 error,
  output logic [DATA_SIZE-1:0] read_data,
  output logic                 read_valid,
  input  logic [DATA_SIZE-1:0] write_data,
  input  logic                 write_valid,
  output resp_state_e          o_dbg_state
);

  // Handshake: a request is held by the initiator until a one-cycle grant or
  // error pulse; after grant, read beats are flagged by read_valid (1 cycle
  // after grant) and write beats are taken on every cycle write_valid is high.

  localparam int         WA_W     = $clog2(MEM_WORDS);
  localparam int         WX_W     = ADDR_SIZE - 1;
  localparam logic [3:0] LAT_LAST = 4'(GRANT_LATENCY - 1);

  resp_state_e           r_state, w_next;
  logic [ADDR_SIZE-1:0]  r_base_addr;
  logic [SIZE_W-1:0]     r_size;
  logic                  r_is_wr;
  logic                  r_both;
  logic [3:0]            r_wait_cnt;
  logic [WA_W-1:0]       r_word;
  logic [SIZE_W-1:0]     r_beat;
  logic                  r_rvalid;
  logic                  w_issue;
  logic                  w_ram_we;
  logic                  w_stall;
  logic [DATA_SIZE-1:0]  w_rdata;

  // Word end address carries one extra bit so an overflowing burst is seen, not wrapped.
  function automatic logic bad_req(input logic both, input logic [ADDR_SIZE-1:0] a,
                                   input logic [SIZE_W-1:0] sz);
    logic [WX_W-1:0] w_end;
    w_end = {1'b0, a[ADDR_SIZE-1:2]} + WX_W'(sz);
    return both || (a[1:0] != 2'b00) || (w_end >= WX_W'(MEM_WORDS));
  endfunction

`ifdef CODMA_RESP_STALL_INJECT_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk_i) begin
    if (reset_i) r_lfsr <= LFSR_SEED;
    else         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    w_issue  = 1'b0;
    w_ram_we = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (read_request || write_request) begin
          if (GRANT_LATENCY == 0)
            w_next = bad_req(read_request && write_request, addr, size) ? ST_ERR : ST_GRANT;
          else
            w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == LAT_LAST)
          w_next = bad_req(r_both, r_base_addr, r_size) ? ST_ERR : ST_GRANT;
      end
      ST_GRANT: begin
        // Beat 0 is read here so it lands on the first RD_DATA cycle.
        w_issue = !r_is_wr;
        w_next  = r_is_wr ? ST_WR_DATA : ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (r_beat != r_size) begin
          w_issue = !w_stall;
        end else if (r_rvalid) begin
          w_next = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        if (write_valid) begin
          w_ram_we = 1'b1;
          if (r_beat == r_size) w_next = ST_IDLE;
        end
      end
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_base_addr <= '0;
      r_size      <= '0;
      r_is_wr     <= 1'b0;
      r_both      <= 1'b0;
      r_wait_cnt  <= '0;
      r_word      <= '0;
      r_beat      <= '0;
      r_rvalid    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= w_issue;
      if (r_state == ST_IDLE && (read_request || write_request)) begin
        r_base_addr <= addr;
        r_size      <= size;
        r_is_wr     <= write_request;
        r_both      <= read_request && write_request;
        r_wait_cnt  <= '0;
        r_word      <= addr[WA_W+1:2];
      end
      if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + 4'd1;
      if (r_state == ST_GRANT) r_beat <= '0;
      if (w_issue) r_word <= r_word + 1'b1;
      if (w_issue && r_state == ST_RD_DATA) r_beat <= r_beat + 1'b1;
      if (w_ram_we) begin
        r_word <= r_word + 1'b1;
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  codma_resp_ram #(
    .DATA_SIZE (DATA_SIZE),
    .MEM_WORDS (MEM_WORDS)
  ) u_ram (
    .i_clk   (clk_i),
    .i_reset (reset_i),
    .i_we    (w_ram_we),
    .i_re    (w_issue),
    .i_addr  (r_word),
    .i_wdata (write_data),
    .o_rdata (w_rdata)
  );

  assign grant       = (r_state == ST_GRANT);
  assign error       = (r_state == ST_ERR);
  assign read_valid  = r_rvalid;
  assign read_data   = w_rdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_codma_bus_responder.sv
// Directed bench for codma_bus_responder: bursts, address errors, mid-burst reset.
module tb_codma_bus_responder;
  import codma_bus_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = 1024;
  localparam int GL = 2;

  // clock / reset
  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  logic          read_request, write_request, write_valid;
  logic [AW-1:0] addr;
  logic [3:0]    size;
  logic [DW-1:0] write_data, read_data;
  logic          grant, error, read_valid;
  resp_state_e   dbg_state;

  codma_bus_responder #(
    .DATA_SIZE(DW), .ADDR_SIZE(AW), .MEM_WORDS(MW), .GRANT_LATENCY(GL)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .read_request(read_request), .write_request(write_request),
    .addr(addr), .size(size), .grant(grant), .error(error),
    .read_data(read_data), .read_valid(read_valid),
    .write_data(write_data), .write_valid(write_valid),
    .o_dbg_state(dbg_state)
  );

  // scoreboard
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [0:MW-1];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // driver tasks
  task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [3:0] sz, output int gnt_cyc, output int err_cyc);
    read_request = rd; write_request = wr; addr = a; size = sz;
    gnt_cyc = 0; err_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      check("grant_error_excl", 32'(grant & error), 32'd0);
      if (grant === 1'b1) begin gnt_cyc = c; break; end
      if (error === 1'b1) begin err_cyc = c; break; end
    end
    read_request = 1'b0; write_request = 1'b0;
    if (gnt_cyc == 0 && err_cyc == 0) check("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input logic [3:0] sz,
                             input logic [DW-1:0] base_val, input int gap_after, input int gap_len);
    int g, e;
    do_req(1'b0, 1'b1, a, sz, g, e);
    check("wr_grant_cyc", 32'(g), 32'(GL + 1));
    if (g == 0) return;
    tick();
    for (int i = 0; i <= int'(sz); i++) begin
      write_valid = 1'b1;
      write_data  = base_val + DW'(i);
      model[int'(a >> 2) + i] = base_val + DW'(i);
      tick();
      write_valid = 1'b0;
      if (i == gap_after - 1) begin
        repeat (gap_len) tick();
        check("wr_gap_state", 32'(dbg_state), 32'(ST_WR_DATA));
      end
    end
    check("wr_done_idle", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input logic [3:0] sz,
                            input int abort_after, output int bubbles);
    int g, e, nb;
    logic [DW-1:0] last;
    bubbles = 0; nb = 0; last = '0;
    for (int i = 0; i <= int'(sz); i++) exp_q.push_back(model[int'(a >> 2) + i]);
    do_req(1'b1, 1'b0, a, sz, g, e);
    check("rd_grant_cyc", 32'(g), 32'(GL + 1));
    if (g == 0) begin exp_q.delete(); return; end
    tick();
    check("rd_first_beat_latency", 32'(read_valid), 32'd1);
    for (int c = 0; c < 80 && nb <= int'(sz); c++) begin
      if (c > 0) tick();
      if (read_valid === 1'b1) begin
        check($sformatf("rd_beat%0d", nb), read_data, exp_q.pop_front());
        last = read_data;
        nb++;
        if (abort_after > 0 && nb == abort_after) begin
          reset_i = 1'b1;
          tick();
          check("abort_rvalid", 32'(read_valid), 32'd0);
          check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
          check("abort_rdata", read_data, 32'd0);
          reset_i = 1'b0;
          exp_q.delete();
          return;
        end
      end else begin
        bubbles++;
      end
    end
    check("rd_beat_count", 32'(nb), 32'(sz) + 32'd1);
    tick();
    check("rd_no_extra_beat", 32'(read_valid), 32'd0);
    check("rd_data_hold", read_data, last);
    check("rd_done_idle", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic expect_error(input string tag, input logic rd, input logic wr,
                              input logic [AW-1:0] a, input logic [3:0] sz);
    int g, e, seen;
    do_req(rd, wr, a, sz, g, e);
    check({tag, "_err_cyc"}, 32'(e), 32'(GL + 1));
    check({tag, "_no_grant"}, 32'(g), 32'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen += int'(read_valid) + int'(grant) + int'(error);
    end
    check({tag, "_quiet_after"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    reset_i = 1'b1; read_request = 1'b0; write_request = 1'b0; write_valid = 1'b0;
    addr = '0; size = '0; write_data = '0;
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_rvalid", 32'(read_valid), 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_i = 1'b0;
    tick();

    write_burst(32'h10, 4'd0, 32'hDEAD_BEEF, 0, 0);
    read_burst(32'h10, 4'd0, 0, b);

    write_burst(32'h40, 4'd3, 32'd1, 2, 2);
    read_burst(32'h40, 4'd3, 0, b);
`ifndef CODMA_RESP_STALL_INJECT_EN
    check("rd_back_to_back", 32'(b), 32'd0);
`endif

    expect_error("misaligned", 1'b1, 1'b0, 32'h13, 4'd0);
    read_burst(32'h10, 4'd0, 0, b);

    write_burst(32'hFF8, 4'd1, 32'hA0, 0, 0);
    read_burst(32'hFF8, 4'd1, 0, b);
    expect_error("overflow", 1'b1, 1'b0, 32'hFFC, 4'd1);

    expect_error("both_req", 1'b1, 1'b1, 32'h10, 4'd0);

    write_burst(32'h80, 4'd7, 32'h100, 0, 0);
    read_burst(32'h80, 4'd7, 3, b);
    tick();
    read_burst(32'h10, 4'd0, 0, b);
    read_burst(32'h40, 4'd3, 0, b);

    write_burst(32'h100, 4'd15, 32'h5000, 0, 0);
    read_burst(32'h100, 4'd15, 0, b);
`ifdef CODMA_RESP_STALL_INJECT_EN
    check("rd_has_bubble", 32'(b > 0), 32'd1);
`else
    check("rd16_back_to_back", 32'(b), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/codma_bus_responder.md
Name: codma_bus_responder

Overview:
- Target-side (responder) end of the CoDMA bus_if: a word-addressed memory model that answers CoDMA read and write bursts.
- Signal set: read_request, write_request, addr, size, grant, read_data, read_valid, write_data, write_valid, error.
- Used as the system-memory endpoint in CoDMA simulation, and as a synthesizable scratch RAM behind the CoDMA in FPGA bring-up.

Parameters:
DATA_SIZE, 32, data bus width in bits (one beat = one word)
ADDR_SIZE, 32, byte-address width
MEM_WORDS, 1024, memory depth in words (power of two)
GRANT_LATENCY, 2, idle cycles between request sample and grant pulse (0..15)

Ports:
clk_i  input  1  sole clock
reset_i  input  1  synchronous, active-high reset
read_request  input  1  initiator read request, held until grant or error
write_request  input  1  initiator write request, held until grant or error
addr  input  ADDR_SIZE  byte start address, word aligned
size  input  4  burst length minus one (1..16 beats)
grant  output  1  one-cycle pulse: request accepted, data phase follows
error  output  1  one-cycle pulse: request rejected, no data phase
read_data  output  DATA_SIZE  read beat data
read_valid  output  1  read_data valid this cycle
write_data  input  DATA_SIZE  write beat data
write_valid  input  1  write beat present this cycle

Behaviour:
- Interface fact: one clock (clk_i); reset_i is synchronous, active-high.
- Reset:
  - grant, error and read_valid are 0; read_data is 0; FSM is in IDLE; counters are 0.
  - Memory contents are not cleared.
  - Reset asserted mid-burst aborts the burst on the next edge and discards any remaining beats.
- FSM states: IDLE, WAIT, GRANT, RD_DATA, WR_DATA, ERR.
- IDLE:
  - On a cycle where read_request or write_request is high, latch addr, size and direction, then go to WAIT.
  - If GRANT_LATENCY = 0, go directly to GRANT.
- WAIT: count GRANT_LATENCY cycles, then evaluate the request.
  - Go to ERR if any of these hold:
    - read_request and write_request were both high at sample;
    - addr[1:0] != 0;
    - (addr>>2) + size >= MEM_WORDS. Compute this with one extra bit so the sum cannot wrap; bursts never wrap around memory.
  - Otherwise go to GRANT.
- ERR: error = 1 for one cycle, then IDLE. grant stays 0.
- GRANT: grant = 1 for one cycle, then RD_DATA or WR_DATA. The initiator drops its request in this cycle; the responder ignores request lines outside IDLE.
- RD_DATA:
  - The first read_valid appears 1 cycle after grant (synchronous RAM read).
  - Beats are back-to-back, size+1 in total, at word addresses base, base+1, ...
  - read_data holds its last value when read_valid = 0.
  - After the last beat, go to IDLE. A new request can be sampled on the cycle after the last beat.
- WR_DATA:
  - Each cycle with write_valid = 1 writes write_data to the next word address.
  - Gaps in write_valid are allowed; there is no timeout.
  - After beat size+1, go to IDLE. write_valid outside WR_DATA is ignored.
- A beat counter (4 bits) counts 0..size. The word address increments by 1 per beat.
- grant and error are never high in the same cycle.

Optional Feature:
- Macro: CODMA_RESP_STALL_INJECT_EN.
- When defined:
  - A 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle.
  - In RD_DATA, a beat is withheld (read_valid = 0, address does not advance) whenever lfsr[0] = 1.
  - This exercises initiator tolerance of read bubbles. Beat count and order are unchanged.
- When undefined: read beats are strictly back-to-back and no LFSR logic is present.

Decomposition:
- Package codma_bus_pkg holds:
  - DATA_SIZE and ADDR_SIZE defaults;
  - the responder state enum;
  - the size field width (4);
  - the LFSR seed constant.
- Sub-module codma_resp_ram: single-port synchronous RAM with MEM_WORDS x DATA_SIZE, one-cycle read latency, write-enable, no reset on the array.
- The FSM, address/beat counters and error checks live in codma_bus_responder.

Test Plan:
- Preload word 4 = 32'hDEAD_BEEF; read addr 0x10, size 0 -> grant at cycle GRANT_LATENCY+1 after request; one read_valid beat of 32'hDEAD_BEEF one cycle after grant.
- Write addr 0x40, size 3, data 1,2,3,4 with a 2-cycle write_valid gap after beat 2 -> then read addr 0x40, size 3 returns 1,2,3,4 on 4 consecutive cycles.
- Read addr 0x13 (misaligned) -> error pulse, no grant, no read_valid; the next valid request is serviced normally.
- MEM_WORDS = 1024: read addr 0xFF8, size 1 -> grant; read addr 0xFFC, size 1 -> error (no wrap to word 0).
- read_request and write_request high together -> error. Then a reset asserted on the 3rd beat of a size-7 read -> read_valid low on the next edge, FSM in IDLE, preloaded memory intact.
- With CODMA_RESP_STALL_INJECT_EN: read size 15 -> exactly 16 read_valid beats in address order, at least one bubble present.
